bot_update_ctrl: RTL and testbench

Sequences the Rojobot-to-CPU status handshake. On every Rojobot register update it snapshots the 32-bit bot status word, raises the update request to the MIPS system, and holds that snapshot stable until the CPU acknowledges. A one-deep shadow buffers updates that arrive while a request is pending. An acknowledge watchdog forces the motor command to stop if the CPU stops servicing updates. It sits between `rojobot31_0` and `mfp_sys` in the 50 MHz domain.

---
 rtl/bot_update_ctrl_pkg.sv | 14 +
 rtl/bot_update_ctrl_if.sv | 22 ++
 rtl/bot_update_ctrl_edge_detect.sv | 33 +++
 rtl/bot_update_ctrl.sv | 129 ++++++++++++
 tb/tb_bot_update_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/bot_update_ctrl_pkg.sv
// Shared definitions for the Rojobot update controller: state encoding,
// bot status word width and the motor stop command.
package bot_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    RELOAD = 2'd2
  } state_t;

  localparam int unsigned BOT_INFO_W = 32;
  localparam logic [7:0]  MOT_STOP   = 8'h00;

endpackage

// File: rtl/bot_update_ctrl_if.sv
// CPU-side update handshake: snapshot word, update request and acknowledge.
// master = update controller, slave = CPU.
interface bot_update_ctrl_if;
  import bot_ctrl_pkg::*;

  logic [BOT_INFO_W-1:0] H_BOT_INFO;
  logic                  H_BOT_UPDATE_SYNC;
  logic                  H_INT_ACK;

  modport master (
    output H_BOT_INFO,
    output H_BOT_UPDATE_SYNC,
    input  H_INT_ACK
  );

  modport slave (
    input  H_BOT_INFO,
    input  H_BOT_UPDATE_SYNC,
    output H_INT_ACK
  );

endinterface

// File: rtl/bot_update_ctrl_edge_detect.sv
// Rising-edge detector for the Rojobot update strobe; BOT_UPD_SYNC_EN adds a
// 2-flop synchronizer in front for strobes from another clock domain.
module bot_upd_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic upd_sysregs,
  output logic rise
);

  logic upd;
  logic upd_q;

`ifdef BOT_UPD_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], upd_sysregs};
  end

  assign upd = sync_q[1];
`else
  assign upd = upd_sysregs;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) upd_q <= 1'b0;
    else        upd_q <= upd;
  end

  assign rise = upd & ~upd_q;

endmodule

// File: rtl/bot_update_ctrl.sv
// Rojobot-to-CPU status handshake: snapshot, request/ack, one-deep shadow,
// saturating overrun count and ack watchdog. Optional macro: BOT_UPD_SYNC_EN.
module bot_update_ctrl
  import bot_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned OVR_W          = 8
) (
  input  logic                  SI_ClkIn,
  input  logic                  SI_Reset_N,
  input  logic                  upd_sysregs,
  input  logic [BOT_INFO_W-1:0] bot_info_in,
  input  logic [7:0]            mot_ctl_in,
  output logic [7:0]            mot_ctl_out,
  output logic [OVR_W-1:0]      overrun_cnt,
  output logic                  timeout_flag,
  bot_update_ctrl_if.master     cpu
);

  localparam int unsigned     TMR_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  rise;
  logic [BOT_INFO_W-1:0] shadow;
  logic                  shadow_vld;
  logic [TMR_W-1:0]      timer;
  logic [TMR_W-1:0]      timer_inc;

  logic load_new, load_shadow, req_set, req_clr;
  logic shd_wr, shd_clr, ovr_inc, tmr_run, tmr_clr;

  bot_upd_edge_detect u_edge (
    .clk         (SI_ClkIn),
    .rst_n       (SI_Reset_N),
    .upd_sysregs (upd_sysregs),
    .rise        (rise)
  );

  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_new    = 1'b0;
    load_shadow = 1'b0;
    req_set     = 1'b0;
    req_clr     = 1'b0;
    shd_wr      = 1'b0;
    shd_clr     = 1'b0;
    ovr_inc     = 1'b0;
    tmr_run     = 1'b0;
    tmr_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          load_new = 1'b1;
          req_set  = 1'b1;
          state_d  = PEND;
        end
      end
      PEND: begin
        tmr_run = 1'b1;
        if (rise) begin
          shd_wr  = 1'b1;
          ovr_inc = shadow_vld;
        end
        if (cpu.H_INT_ACK) begin
          req_clr = 1'b1;
          tmr_clr = 1'b1;
          state_d = (rise || shadow_vld) ? RELOAD : IDLE;
        end
      end
      RELOAD: begin
        load_shadow = 1'b1;
        req_set     = 1'b1;
        state_d     = PEND;
        // An update arriving during the reload refills the shadow without loss.
        if (rise) shd_wr  = 1'b1;
        else      shd_clr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign timer_inc = timer + 1'b1;

  always_ff @(posedge SI_ClkIn) begin
    if (!SI_Reset_N) begin
      cpu.H_BOT_INFO        <= '0;
      cpu.H_BOT_UPDATE_SYNC <= 1'b0;
      shadow                <= '0;
      shadow_vld            <= 1'b0;
      overrun_cnt           <= '0;
      timer                 <= '0;
      timeout_flag          <= 1'b0;
      mot_ctl_out           <= '0;
    end else begin
      if (load_new)         cpu.H_BOT_INFO <= bot_info_in;
      else if (load_shadow) cpu.H_BOT_INFO <= shadow;

      if (req_set)      cpu.H_BOT_UPDATE_SYNC <= 1'b1;
      else if (req_clr) cpu.H_BOT_UPDATE_SYNC <= 1'b0;

      if (shd_wr) begin
        shadow     <= bot_info_in;
        shadow_vld <= 1'b1;
      end else if (shd_clr) begin
        shadow_vld <= 1'b0;
      end

      if (ovr_inc && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + 1'b1;

      // Flag rises on the edge the timer lands on TIMEOUT_CYCLES-1, then holds.
      if (tmr_clr) begin
        timer        <= '0;
        timeout_flag <= 1'b0;
      end else if (tmr_run && (timer != TMR_MAX)) begin
        timer <= timer_inc;
        if (timer_inc == TMR_MAX) timeout_flag <= 1'b1;
      end

      mot_ctl_out <= timeout_flag ? MOT_STOP : mot_ctl_in;
    end
  end

endmodule

// File: tb/tb_bot_update_ctrl.sv
// Directed self-checking bench for bot_update_ctrl (TIMEOUT_CYCLES=16, OVR_W=8).
module tb_bot_update_ctrl;
  import bot_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd;
  logic [31:0] info;
  logic [7:0]  mot_in;
  logic [7:0]  mot_out;
  logic [7:0]  ovr;
  logic        tflag;

  int n_checks = 0;
  int n_errors = 0;

  bot_update_ctrl_if cpu_if ();

  bot_update_ctrl #(
    .TIMEOUT_CYCLES (16),
    .OVR_W          (8)
  ) dut (
    .SI_ClkIn     (clk),
    .SI_Reset_N   (rst_n),
    .upd_sysregs  (upd),
    .bot_info_in  (info),
    .mot_ctl_in   (mot_in),
    .mot_ctl_out  (mot_out),
    .overrun_cnt  (ovr),
    .timeout_flag (tflag),
    .cpu          (cpu_if.master)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_upd(input logic [31:0] d);
    upd  = 1'b1;
    info = d;
    step();
    upd  = 1'b0;
    step();
  endtask

  initial begin
    rst_n            = 1'b0;
    upd              = 1'b0;
    info             = '0;
    mot_in           = 8'h00;
    cpu_if.H_INT_ACK = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_info", cpu_if.H_BOT_INFO, 32'h0);
    check("rst_sync", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_flag", 32'(tflag), 32'd0);
    check("rst_mot", 32'(mot_out), 32'd0);

    // Single update, ack after 5 request cycles
    upd  = 1'b1;
    info = 32'h1234_5678;
    step();
    upd = 1'b0;
    check("t1_info", cpu_if.H_BOT_INFO, 32'h1234_5678);
    check("t1_sync_hi", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_sync_hold", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd1);
    end
    cpu_if.H_INT_ACK = 1'b1;
    step();
    cpu_if.H_INT_ACK = 1'b0;
    check("t1_sync_lo", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd0);
    step();
    check("t1_idle", 32'(dut.state_q), 32'(IDLE));
    check("t1_no_rereq", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd0);
    check("t1_ovr", 32'(ovr), 32'd0);
    check("t1_info_hold", cpu_if.H_BOT_INFO, 32'h1234_5678);

    // Three updates A,B,C; newest wins, one overrun
    send_upd(32'hAAAA_0001);
    check("t2_infoA", cpu_if.H_BOT_INFO, 32'hAAAA_0001);
    send_upd(32'hBBBB_0002);
    check("t2_ovr0", 32'(ovr), 32'd0);
    send_upd(32'hCCCC_0003);
    check("t2_ovr1", 32'(ovr), 32'd1);
    check("t2_info_stable", cpu_if.H_BOT_INFO, 32'hAAAA_0001);
    cpu_if.H_INT_ACK = 1'b1;
    step();
    cpu_if.H_INT_ACK = 1'b0;
    check("t2_gap", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd0);
    step();
    check("t2_rereq", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd1);
    check("t2_infoC", cpu_if.H_BOT_INFO, 32'hCCCC_0003);
    cpu_if.H_INT_ACK = 1'b1;
    step();
    cpu_if.H_INT_ACK = 1'b0;
    step();
    check("t2_done", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd0);
    check("t2_idle", 32'(dut.state_q), 32'(IDLE));

    // Ack and update in the same cycle, shadow empty
    send_upd(32'hDDDD_0004);
    check("t3_infoD", cpu_if.H_BOT_INFO, 32'hDDDD_0004);
    upd              = 1'b1;
    info             = 32'hEEEE_0005;
    cpu_if.H_INT_ACK = 1'b1;
    step();
    upd              = 1'b0;
    cpu_if.H_INT_ACK = 1'b0;
    check("t3_gap", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd0);
    check("t3_ovr", 32'(ovr), 32'd1);
    step();
    check("t3_rereq", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd1);
    check("t3_infoE", cpu_if.H_BOT_INFO, 32'hEEEE_0005);
    cpu_if.H_INT_ACK = 1'b1;
    step();
    cpu_if.H_INT_ACK = 1'b0;
    step();
    check("t3_idle", 32'(dut.state_q), 32'(IDLE));

    // Watchdog: flag in PEND cycle 16, motor stop the cycle after
    mot_in = 8'h33;
    step();
    check("t4_mot_pass", 32'(mot_out), 32'h33);
    send_upd(32'hF00D_0006);
    for (int i = 3; i <= 15; i++) step();
    check("t4_flag_lo", 32'(tflag), 32'd0);
    step();
    check("t4_flag_hi", 32'(tflag), 32'd1);
    check("t4_mot_lag", 32'(mot_out), 32'h33);
    step();
    check("t4_mot_stop", 32'(mot_out), 32'h00);
    check("t4_req_held", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd1);
    cpu_if.H_INT_ACK = 1'b1;
    step();
    cpu_if.H_INT_ACK = 1'b0;
    check("t4_flag_clr", 32'(tflag), 32'd0);
    check("t4_mot_still", 32'(mot_out), 32'h00);
    step();
    check("t4_mot_back", 32'(mot_out), 32'h33);

    // Reset during PEND with valid shadow
    send_upd(32'h0000_0007);
    send_upd(32'h0000_0008);
    rst_n = 1'b0;
    step();
    check("t5_info", cpu_if.H_BOT_INFO, 32'h0);
    check("t5_sync", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd0);
    check("t5_ovr", 32'(ovr), 32'd0);
    check("t5_mot", 32'(mot_out), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check("t5_no_rereq", 32'(cpu_if.H_BOT_UPDATE_SYNC), 32'd0);
    check("t5_idle", 32'(dut.state_q), 32'(IDLE));

    // Overrun saturation
    send_upd(32'h1111_0000);
    send_upd(32'h2222_0000);
    for (int i = 1; i <= 300; i++) begin
      send_upd(32'(i));
      if (i == 254) check("t6_ovr_fe", 32'(ovr), 32'hFE);
    end
    check("t6_ovr_sat", 32'(ovr), 32'hFF);
    check("t6_info_stable", cpu_if.H_BOT_INFO, 32'h1111_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
